count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Receive-side checker for the free-running `count` bus produced by the counter block.
- Samples `count` every clock and checks that each sample is the previous value +1, modulo 2^WIDTH.
- Reports sequence errors, lock status and a sticky threshold-reached flag.
- Sits next to the counter, in RTL or as a synthesizable bench monitor, replacing ad-hoc `$display` and `wait` checks.

Parameters:
- WIDTH, 16, width of the monitored count bus.
- THRESHOLD, 256, unsigned count value at which done asserts.
- ERR_W, 8, width of the saturating error counter.
- LOCK_N, 4, consecutive correct increments required to assert locked (1 to 255).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  monitor enable; sampling and checking happen only while high.
- count  input  WIDTH  observed counter value.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  high after LOCK_N consecutive correct increments.
- err  output  1  one-cycle pulse per sequence mismatch.
- err_cnt  output  ERR_W  saturating mismatch count.
- done  output  1  sticky: a sampled count was >= THRESHOLD.
- last_count  output  WIDTH  most recent sampled count.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a rising edge:
  - state=IDLE;
  - locked=0, err=0, err_cnt=0, done=0, last_count=0, good_run=0.
  - rst asserted mid-operation aborts everything, including DONE.
- Latency: every output is registered and reflects the sample taken at the same edge; visible the cycle after count is presented.
- FSM states: IDLE, TRACK, DONE.
- IDLE:
  - en=0: hold.
  - en=1: capture last_count=count, good_run=0, go to TRACK. No compare on this first sample.
- TRACK with en=1: expected = last_count+1, truncated to WIDTH bits (0xFFFF->0x0000 is a match).
  - Match: good_run increments, saturating at LOCK_N. locked=1 once good_run reaches LOCK_N.
  - Mismatch: err=1 for exactly one cycle, err_cnt increments (saturating at all-ones), locked=0, good_run=0.
  - Either case: last_count=count. A mismatch therefore resyncs to the observed value.
- TRACK with en=0: return to IDLE, locked=0, good_run=0. err_cnt and done are kept.
- Threshold: any enabled sample with count >= THRESHOLD (IDLE capture or TRACK) sets done=1 and moves to DONE.
  - THRESHOLD=0: done on the first enabled sample.
  - THRESHOLD > 2^WIDTH-1: done never asserts.
- Simultaneous mismatch and threshold: err pulse, err_cnt increment and done all occur together; next state is DONE.
- DONE: no further checking. err=0, locked holds its value, last_count frozen, clr_err still effective. Leaves only via rst.
- clr_err:
  - Sets err_cnt=0.
  - Same cycle as a mismatch: err_cnt=1, because the increment applies after the clear.
  - No effect on err, locked or done.
- err_cnt at all-ones stays all-ones on further mismatches; err still pulses.

Optional Feature:
- Macro: COUNT_MON_HOLD_OK_EN.
- Defined: in TRACK, count == last_count is treated as a stall, not an error.
  - No err, no err_cnt change, good_run and locked held.
  - Supports a counter with clock enable.
- Undefined: a repeated value is an ordinary mismatch.

Decomposition:
- Package count_mon_pkg:
  - state enum: IDLE=2'b00, TRACK=2'b01, DONE=2'b10;
  - default constants CM_WIDTH=16, CM_THRESHOLD=256, CM_ERR_W=8, CM_LOCK_N=4.
- Sub-module count_mon_satcnt: parameterized saturating up-counter with synchronous clear and increment inputs (increment applied after clear). Instantiated for err_cnt and good_run.

Test Plan:
1. Reset, then en=1 with count driven 0,1,2,…,5 → locked rises the cycle after sample 4; err never asserts; err_cnt=0.
2. Sequence 10,11,12,20,21 → single err pulse after sample 20; err_cnt=1; locked=0; next sample 21 matches (resynced); locked returns after 4 more good increments.
3. WIDTH=16, sequence 0xFFFE,0xFFFF,0x0000,0x0001 → no err (wrap is a match). With THRESHOLD=256, done asserts after sample 0xFFFE; state=DONE; later samples ignored.
4. THRESHOLD=256, increasing count from 250 → done=1 the cycle after sample 256; last_count=256, frozen; subsequent bad values give no err.
5. err_cnt=3, then clr_err=1 in the same cycle as a mismatch → err_cnt=1. Then 300 forced mismatches with ERR_W=8 → err_cnt=255, err still pulses each time.
6. Sequence 7,7,8 → undefined macro: err once after second 7; defined COUNT_MON_HOLD_OK_EN: no err, 8 matches. Also: rst=1 while in DONE → all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/count_mon_pkg.sv
// count_mon_pkg
//   Shared types and default constants for the count_monitor block.
//   state_t : monitor FSM encoding (IDLE / TRACK / DONE)
//   CM_*    : default parameter values used by the interface and the top.
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int          CM_WIDTH     = 16;
  localparam int unsigned CM_THRESHOLD = 256;
  localparam int          CM_ERR_W     = 8;
  localparam int          CM_LOCK_N    = 4;

endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if
//   Bundles the observed count bus, the monitor controls and the monitor
//   status outputs.
//   master : drives en, count, clr_err; observes the status outputs
//   slave  : the monitor itself (consumes controls, drives status)
//   Signals: en, count[WIDTH], clr_err, locked, err, err_cnt[ERR_W], done,
//            last_count[WIDTH]
interface count_monitor_if
  import count_mon_pkg::*;
#(
  parameter int WIDTH = CM_WIDTH,
  parameter int ERR_W = CM_ERR_W
);
  logic             en;
  logic [WIDTH-1:0] count;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             done;
  logic [WIDTH-1:0] last_count;

  modport master (
    output en, count, clr_err,
    input  locked, err, err_cnt, done, last_count
  );

  modport slave (
    input  en, count, clr_err,
    output locked, err, err_cnt, done, last_count
  );
endinterface

// File: rtl/count_mon_satcnt.sv
// count_mon_satcnt
//   Saturating up-counter with synchronous clear and increment. When clr and
//   inc arrive together the clear is applied first, so the result is 1.
//   Ports: clk, rst (sync, active-high), clr, inc, q[W] (count value)
//   Parameters: W (counter width), MAX (saturation value)
module count_mon_satcnt #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (base != MAX)) begin
      q <= base + W'(1);
    end else begin
      q <= base;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor
//   Receive-side checker for a free-running counter bus. Every enabled clock
//   the sampled count must equal the previous sample + 1 (mod 2^WIDTH).
//   Reports a one-cycle err pulse per mismatch, a saturating err_cnt, a
//   locked flag after LOCK_N consecutive good increments and a sticky done
//   flag once a sample reaches THRESHOLD. All outputs are registered.
//   Ports: clk, rst (sync, active-high), mon (count_monitor_if.slave)
//   Optional build macro COUNT_MON_HOLD_OK_EN: a repeated value while
//   tracking is treated as a counter stall instead of a mismatch.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int          WIDTH     = CM_WIDTH,
  parameter int unsigned THRESHOLD = CM_THRESHOLD,
  parameter int          ERR_W     = CM_ERR_W,
  parameter int          LOCK_N    = CM_LOCK_N
) (
  input  logic            clk,
  input  logic            rst,
  count_monitor_if.slave  mon
);

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [7:0]       RUN_MAX  = 8'(LOCK_N);
  localparam logic [7:0]       LOCK_PRE = 8'(LOCK_N - 1);

  state_t           state, state_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [7:0]       good_run;
  logic             run_clr, run_inc, err_inc;
  logic [WIDTH-1:0] expected;
  logic             match, stall, hit;

  // Compare in 64 bits so a THRESHOLD above the count range never fires.
  function automatic logic thr_hit(input logic [WIDTH-1:0] c);
    return 64'(c) >= 64'(THRESHOLD);
  endfunction

  assign expected = last_q + WIDTH'(1);
  assign match    = (mon.count == expected);
  assign hit      = thr_hit(mon.count);

`ifdef COUNT_MON_HOLD_OK_EN
  assign stall = (mon.count == last_q);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    err_d    = 1'b0;
    locked_d = locked_q;
    done_d   = done_q;
    last_d   = last_q;
    run_clr  = 1'b0;
    run_inc  = 1'b0;
    err_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (mon.en) begin
          // First sample only seeds the comparison.
          last_d  = mon.count;
          run_clr = 1'b1;
          if (hit) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        if (!mon.en) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          run_clr  = 1'b1;
        end else begin
          last_d = mon.count;  // mismatch resyncs to the observed value
          if (stall) begin
            // counter held its value: nothing changes
          end else if (match) begin
            run_inc = 1'b1;
            if (good_run >= LOCK_PRE) locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            run_clr  = 1'b1;
          end
          if (hit) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // terminal until reset; only clr_err still acts (in err counter)
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      state    <= state_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

  count_mon_satcnt #(
    .W   (ERR_W),
    .MAX (ERR_MAX)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (mon.clr_err),
    .inc (err_inc),
    .q   (mon.err_cnt)
  );

  count_mon_satcnt #(
    .W   (8),
    .MAX (RUN_MAX)
  ) u_good_run (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (run_inc),
    .q   (good_run)
  );

  assign mon.err        = err_q;
  assign mon.locked     = locked_q;
  assign mon.done       = done_q;
  assign mon.last_count = last_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
//   Bench for count_monitor (WIDTH=16, THRESHOLD=256, ERR_W=8, LOCK_N=4) plus
//   a second instance with THRESHOLD above the count range for wrap checks.
module tb_count_monitor;

  logic clk;
  logic rst;

  count_monitor_if #(.WIDTH(16), .ERR_W(8)) ifm ();
  count_monitor_if #(.WIDTH(16), .ERR_W(8)) ifw ();

  assign ifw.en      = ifm.en;
  assign ifw.count   = ifm.count;
  assign ifw.clr_err = ifm.clr_err;

  count_monitor #(.WIDTH(16), .THRESHOLD(256), .ERR_W(8), .LOCK_N(4)) dut (
    .clk (clk),
    .rst (rst),
    .mon (ifm)
  );

  count_monitor #(.WIDTH(16), .THRESHOLD(70000), .ERR_W(8), .LOCK_N(4)) dutw (
    .clk (clk),
    .rst (rst),
    .mon (ifw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: unbounded counts, clamped only when compared.
  bit m_seen, m_fin, m_err, m_done;
  int m_last, m_run, m_errs;

  function automatic void model_reset();
    m_seen = 0; m_fin = 0; m_err = 0; m_done = 0;
    m_last = 0; m_run = 0; m_errs = 0;
  endfunction

  function automatic void model_step(bit e, int c, bit clr);
    m_err = 0;
    if (clr) m_errs = 0;
    if (m_fin) return;
    if (!e) begin
      m_seen = 0;
      m_run  = 0;
      return;
    end
    if (!m_seen) begin
      m_seen = 1;
      m_run  = 0;
    end else begin
`ifdef COUNT_MON_HOLD_OK_EN
      if (c == m_last) begin
        // stall
      end else
`endif
      if (c == (m_last + 1) % 65536) m_run++;
      else begin
        m_err = 1;
        m_errs++;
        m_run = 0;
      end
    end
    m_last = c;
    if (c >= 256) begin
      m_done = 1;
      m_fin  = 1;
    end
  endfunction

  function automatic logic exp_locked();
    return m_run >= 4;
  endfunction

  function automatic logic [7:0] exp_errcnt();
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
  endfunction

  task automatic step(input bit e, input logic [15:0] c, input bit clr);
    ifm.en      = e;
    ifm.count   = c;
    ifm.clr_err = clr;
    @(posedge clk);
    #1;
    model_step(e, int'(c), clr);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ifm.en      = 1'($urandom);
    ifm.count   = 16'($urandom);
    ifm.clr_err = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifm.en = 1'b0;
    ifm.clr_err = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({ifm.locked, ifm.err, ifm.done} !== 3'b000 || ifm.err_cnt !== 8'd0 ||
        ifm.last_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: locked=%b err=%b done=%b err_cnt=%0d last=%0d, required all 0",
               ifm.locked, ifm.err, ifm.done, ifm.err_cnt, ifm.last_count);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      step(1'b1, 16'(i), 1'b0);
      n_tests++;
      if (ifm.locked !== (i >= 4) || ifm.err !== 1'b0) begin
        n_fail++;
        $display("FAIL lock sample %0d: locked=%b err=%b, required locked=%b err=0",
                 i, ifm.locked, ifm.err, (i >= 4));
      end
    end
    n_tests++;
    if (ifm.err_cnt !== 8'd0 || ifm.last_count !== 16'd5) begin
      n_fail++;
      $display("FAIL lock end: err_cnt=%0d last=%0d, required 0 and 5", ifm.err_cnt, ifm.last_count);
    end
  endtask

  task automatic test_resync();
    logic [15:0] seq [9] = '{16'd10, 16'd11, 16'd12, 16'd20, 16'd21,
                             16'd22, 16'd23, 16'd24, 16'd25};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_tests++;
      if (ifm.err !== (i == 3) || ifm.locked !== (i >= 7) || ifm.err_cnt !== ((i >= 3) ? 8'd1 : 8'd0)) begin
        n_fail++;
        $display("FAIL resync sample %0d: err=%b locked=%b err_cnt=%0d, required err=%b locked=%b err_cnt=%0d",
                 seq[i], ifm.err, ifm.locked, ifm.err_cnt, (i == 3), (i >= 7), (i >= 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] seq [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_tests++;
      if (ifw.err !== 1'b0 || ifm.err !== 1'b0 || ifm.done !== 1'b1 || ifm.last_count !== 16'hFFFE) begin
        n_fail++;
        $display("FAIL wrap sample %h: wide err=%b err=%b done=%b last=%h, required 0 0 1 fffe",
                 seq[i], ifw.err, ifm.err, ifm.done, ifm.last_count);
      end
    end
    n_tests++;
    if (ifw.last_count !== 16'h0001 || ifw.err_cnt !== 8'd0 || ifw.done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap wide end: last=%h err_cnt=%0d done=%b, required 0001 0 0",
               ifw.last_count, ifw.err_cnt, ifw.done);
    end
  endtask

  task automatic test_threshold();
    logic [15:0] bad [3] = '{16'd9, 16'd77, 16'd300};
    do_reset();
    for (int v = 250; v <= 256; v++) begin
      step(1'b1, 16'(v), 1'b0);
      n_tests++;
      if (ifm.done !== (v == 256)) begin
        n_fail++;
        $display("FAIL threshold sample %0d: done=%b, required %b", v, ifm.done, (v == 256));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bad[i], 1'b0);
      n_tests++;
      if (ifm.err !== 1'b0 || ifm.last_count !== 16'd256 || ifm.done !== 1'b1 || ifm.err_cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL threshold frozen %0d: err=%b last=%0d done=%b err_cnt=%0d, required 0 256 1 0",
                 bad[i], ifm.err, ifm.last_count, ifm.done, ifm.err_cnt);
      end
    end
  endtask

  task automatic test_clr_sat();
    do_reset();
    step(1'b1, 16'd0, 1'b0);
    step(1'b1, 16'd5, 1'b0);
    step(1'b1, 16'd100, 1'b0);
    step(1'b1, 16'd5, 1'b0);
    n_tests++;
    if (ifm.err_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL clr pre count: err_cnt=%0d, required 3", ifm.err_cnt);
    end
    step(1'b1, 16'd100, 1'b1);
    n_tests++;
    if (ifm.err_cnt !== 8'd1 || ifm.err !== 1'b1) begin
      n_fail++;
      $display("FAIL clr with mismatch: err_cnt=%0d err=%b, required 1 1", ifm.err_cnt, ifm.err);
    end
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 0) ? 16'd5 : 16'd100, 1'b0);
      n_tests++;
      if (ifm.err !== 1'b1 || ifm.err_cnt !== exp_errcnt()) begin
        n_fail++;
        $display("FAIL saturate iter %0d: err=%b err_cnt=%0d, required 1 %0d", i, ifm.err, ifm.err_cnt, exp_errcnt());
      end
    end
    n_tests++;
    if (ifm.err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate end: err_cnt=%0d, required 255", ifm.err_cnt);
    end
  endtask

  task automatic test_repeat();
    logic [15:0] seq [3] = '{16'd7, 16'd7, 16'd8};
    logic e_exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq[i], 1'b0);
`ifdef COUNT_MON_HOLD_OK_EN
      e_exp = 1'b0;
`else
      e_exp = (i == 1);
`endif
      n_tests++;
      if (ifm.err !== e_exp || ifm.err !== m_err) begin
        n_fail++;
        $display("FAIL repeat sample %0d idx %0d: err=%b, required %b", seq[i], i, ifm.err, e_exp);
      end
    end
  endtask

  task automatic test_random();
    int cur = 0;
    bit e, clr;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      e   = ($urandom % 10) != 0;
      clr = ($urandom % 16) == 0;
      case ($urandom % 8)
        0:       cur = $urandom % 250;
        1:       cur = cur;
        default: cur = (cur >= 249) ? ($urandom % 50) : cur + 1;
      endcase
      step(e, 16'(cur), clr);
      n_tests++;
      if (ifm.err !== m_err || ifm.locked !== exp_locked() || ifm.err_cnt !== exp_errcnt() ||
          ifm.done !== m_done || ifm.last_count !== 16'(m_last)) begin
        n_fail++;
        $display("FAIL random cyc %0d: err=%b locked=%b err_cnt=%0d done=%b last=%0d, required %b %b %0d %b %0d",
                 i, ifm.err, ifm.locked, ifm.err_cnt, ifm.done, ifm.last_count,
                 m_err, exp_locked(), exp_errcnt(), m_done, m_last);
      end
    end
    step(1'b1, 16'd300, 1'b0);
    step(1'b1, 16'd301, 1'b0);
    n_tests++;
    if (ifm.done !== 1'b1 || ifm.last_count !== 16'd300 || ifm.err !== 1'b0 || ifm.locked !== exp_locked()) begin
      n_fail++;
      $display("FAIL random done: done=%b last=%0d err=%b locked=%b, required 1 300 0 %b",
               ifm.done, ifm.last_count, ifm.err, ifm.locked, exp_locked());
    end
  endtask

  task automatic test_rst_in_done();
    do_reset();
    for (int v = 253; v <= 258; v++) step(1'b1, 16'(v), 1'b0);
    do_reset();
    n_tests++;
    if ({ifm.locked, ifm.err, ifm.done} !== 3'b000 || ifm.err_cnt !== 8'd0 || ifm.last_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst in done: locked=%b err=%b done=%b err_cnt=%0d last=%0d, required all 0",
               ifm.locked, ifm.err, ifm.done, ifm.err_cnt, ifm.last_count);
    end
    step(1'b1, 16'd3, 1'b0);
    step(1'b1, 16'd9, 1'b0);
    n_tests++;
    if (ifm.last_count !== 16'd9 || ifm.err !== 1'b1 || ifm.done !== 1'b0) begin
      n_fail++;
      $display("FAIL after rst: last=%0d err=%b done=%b, required 9 1 0", ifm.last_count, ifm.err, ifm.done);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifm.en = 1'b0;
    ifm.count = '0;
    ifm.clr_err = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_resync();
    test_wrap();
    test_threshold();
    test_clr_sat();
    test_repeat();
    test_random();
    test_rst_in_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
